axis_mii_rx: RTL and testbench

- 100M MII receive MAC, the RX counterpart to the team's MII transmit path.
- Samples MII nibbles on a clock enable, finds the preamble and SFD, assembles octets, and checks the FCS.
- Emits frame data, with the FCS stripped, as an AXI stream carrying last and err markers, plus Clause 4 style receive status pulses.
- Sits between the PHY-facing MII pins (after synchronisation) and the RX FIFO.

---
 rtl/axis_mii_rx_if.sv | 41 ++++
 rtl/axis_mii_rx.sv | 218 +++++++++++++++++++++
 tb/tb_axis_mii_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_mii_rx_if.sv
// MII receive pins (already synchronised to clk) plus the AXI stream beat and status pulses of axis_mii_rx.
// The length_error member exists only when AXIS_MII_RX_LEN_CHECK_EN is defined.
interface axis_mii_rx_if;
    logic       mii_rx_ce;
    logic       mii_rx_dv;
    logic       mii_rx_er;
    logic [3:0] mii_rxd;
    logic [7:0] axis_data;
    logic       axis_valid;
    logic       axis_last;
    logic       axis_err;
    logic       frame_ok;
    logic       fcs_error;
    logic       align_error;
    logic       rx_error;
`ifdef AXIS_MII_RX_LEN_CHECK_EN
    logic       length_error;

    modport master (
        input  mii_rx_ce, mii_rx_dv, mii_rx_er, mii_rxd,
        output axis_data, axis_valid, axis_last, axis_err,
        output frame_ok, fcs_error, align_error, rx_error, length_error
    );
    modport slave (
        output mii_rx_ce, mii_rx_dv, mii_rx_er, mii_rxd,
        input  axis_data, axis_valid, axis_last, axis_err,
        input  frame_ok, fcs_error, align_error, rx_error, length_error
    );
`else
    modport master (
        input  mii_rx_ce, mii_rx_dv, mii_rx_er, mii_rxd,
        output axis_data, axis_valid, axis_last, axis_err,
        output frame_ok, fcs_error, align_error, rx_error
    );
    modport slave (
        output mii_rx_ce, mii_rx_dv, mii_rx_er, mii_rxd,
        input  axis_data, axis_valid, axis_last, axis_err,
        input  frame_ok, fcs_error, align_error, rx_error
    );
`endif
endinterface

// File: rtl/axis_mii_rx.sv
// 100M MII receive MAC: preamble/SFD hunt, octet assembly, FCS check and strip, AXI stream out.
// Optional frame length checking is built in when AXIS_MII_RX_LEN_CHECK_EN is defined.
//
// state    | meaning
// IDLE     | waiting for dv with a preamble nibble
// PREAMBLE | counting 0x5 nibbles until the SFD nibble 0xD
// DATA     | assembling octets, holding the last 4 back as candidate FCS
// DROP     | discarding the rest of a bad/oversized frame until dv falls
module axis_mii_rx #(
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int MIN_FRAME_BYTES = 64
) (
    input  logic          clk,
    input  logic          rst,
    axis_mii_rx_if.master rx_bus
);
    localparam logic [1:0]  S_IDLE      = 2'd0;
    localparam logic [1:0]  S_PREAMBLE  = 2'd1;
    localparam logic [1:0]  S_DATA      = 2'd2;
    localparam logic [1:0]  S_DROP      = 2'd3;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] CNT_SAT     = 11'd2047;
`ifdef AXIS_MII_RX_LEN_CHECK_EN
    localparam logic [10:0] MAX_L       = 11'(MAX_FRAME_BYTES);
    localparam logic [10:0] MIN_L       = 11'(MIN_FRAME_BYTES);
`endif

    function automatic logic [31:0] crc_octet(input logic [31:0] crc, input logic [7:0] octet);
        logic [31:0] r;
        r = crc ^ {24'd0, octet};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic        phase_q, phase_d;
    logic [3:0]  lo_q, lo_d;
    logic [31:0] hold_q, hold_d;
    logic [2:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        er_seen_q, er_seen_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic        ok_q, ok_d, fcs_q, fcs_d, align_q, align_d, rxe_q, rxe_d, len_q, len_d;
    logic [7:0]  octet;
    logic        eof_fcs, eof_len, eof_bad;

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        phase_d    = phase_q;
        lo_d       = lo_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        er_seen_d  = er_seen_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        err_d      = 1'b0;
        ok_d       = 1'b0;
        fcs_d      = 1'b0;
        align_d    = 1'b0;
        rxe_d      = 1'b0;
        len_d      = 1'b0;
        octet      = {rx_bus.mii_rxd, lo_q};
        // Without a pending octet the frame never reached 5 octets, so it cannot carry a valid FCS.
        eof_fcs    = (crc_q != CRC_RESIDUE) || !pend_vld_q;
`ifdef AXIS_MII_RX_LEN_CHECK_EN
        eof_len    = (cnt_q < MIN_L) || (cnt_q > MAX_L);
`else
        eof_len    = 1'b0;
`endif
        eof_bad    = eof_fcs || phase_q || er_seen_q || eof_len;

        if (rx_bus.mii_rx_ce) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_bus.mii_rx_dv)
                        state_d = (rx_bus.mii_rxd == 4'h5) ? S_PREAMBLE : S_DROP;
                end
                S_PREAMBLE: begin
                    if (!rx_bus.mii_rx_dv) begin
                        state_d = S_IDLE;
                    end else if (rx_bus.mii_rx_er) begin
                        state_d = S_DROP;
                    end else if (rx_bus.mii_rxd == 4'hD) begin
                        state_d    = S_DATA;
                        crc_d      = CRC_INIT;
                        phase_d    = 1'b0;
                        hold_cnt_d = 3'd0;
                        pend_vld_d = 1'b0;
                        er_seen_d  = 1'b0;
                        cnt_d      = 11'd0;
                    end else if (rx_bus.mii_rxd != 4'h5) begin
                        state_d = S_DROP;
                    end
                end
                S_DATA: begin
                    if (!rx_bus.mii_rx_dv) begin
                        state_d    = S_IDLE;
                        valid_d    = pend_vld_q;
                        last_d     = pend_vld_q;
                        err_d      = pend_vld_q && eof_bad;
                        data_d     = pend_q;
                        pend_vld_d = 1'b0;
                        ok_d       = !eof_bad;
                        fcs_d      = eof_fcs;
                        align_d    = phase_q;
                        rxe_d      = er_seen_q;
                        len_d      = eof_len;
                    end else begin
                        if (rx_bus.mii_rx_er)
                            er_seen_d = 1'b1;
                        if (!phase_q) begin
                            lo_d    = rx_bus.mii_rxd;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            crc_d   = crc_octet(crc_q, octet);
                            cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 11'd1;
                            hold_d  = {octet, hold_q[31:8]};
                            if (hold_cnt_q == 3'd4) begin
                                pend_d     = hold_q[7:0];
                                pend_vld_d = 1'b1;
                                valid_d    = pend_vld_q;
                                data_d     = pend_q;
                            end else begin
                                hold_cnt_d = hold_cnt_q + 3'd1;
                            end
`ifdef AXIS_MII_RX_LEN_CHECK_EN
                            // This octet takes the frame past the limit: close it out here.
                            if (cnt_q == MAX_L) begin
                                state_d    = S_DROP;
                                last_d     = 1'b1;
                                err_d      = 1'b1;
                                pend_vld_d = 1'b0;
                                len_d      = 1'b1;
                                rxe_d      = er_seen_q || rx_bus.mii_rx_er;
                            end
`endif
                        end
                    end
                end
                default: begin
                    if (!rx_bus.mii_rx_dv)
                        state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            crc_q      <= CRC_INIT;
            phase_q    <= 1'b0;
            lo_q       <= 4'd0;
            hold_q     <= 32'd0;
            hold_cnt_q <= 3'd0;
            pend_q     <= 8'd0;
            pend_vld_q <= 1'b0;
            er_seen_q  <= 1'b0;
            cnt_q      <= 11'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            ok_q       <= 1'b0;
            fcs_q      <= 1'b0;
            align_q    <= 1'b0;
            rxe_q      <= 1'b0;
            len_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            phase_q    <= phase_d;
            lo_q       <= lo_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            er_seen_q  <= er_seen_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            err_q      <= err_d;
            ok_q       <= ok_d;
            fcs_q      <= fcs_d;
            align_q    <= align_d;
            rxe_q      <= rxe_d;
            len_q      <= len_d;
        end
    end

    assign rx_bus.axis_data   = data_q;
    assign rx_bus.axis_valid  = valid_q;
    assign rx_bus.axis_last   = last_q;
    assign rx_bus.axis_err    = err_q;
    assign rx_bus.frame_ok    = ok_q;
    assign rx_bus.fcs_error   = fcs_q;
    assign rx_bus.align_error = align_q;
    assign rx_bus.rx_error    = rxe_q;
`ifdef AXIS_MII_RX_LEN_CHECK_EN
    assign rx_bus.length_error = len_q;
`else
    logic unused_len;
    assign unused_len = ^{len_q, MAX_FRAME_BYTES, MIN_FRAME_BYTES};
`endif
endmodule

// File: tb/tb_axis_mii_rx.sv
// Directed and randomized frames through axis_mii_rx, checked against a frame-level reference model.
module tb_axis_mii_rx;
    localparam int MAX_B = 1518;
    localparam int MIN_B = 64;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] d; logic l; logic e; int cyc; } beat_t;
    typedef struct { logic ok; logic fcs; logic aln; logic rxe; logic len; int cyc; } stat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    last_ce = 0;
    int    eof_ce = 0;
    beat_t beats[$];
    stat_t stats[$];
    logic  len_obs;

    axis_mii_rx_if bus ();

    axis_mii_rx #(.MAX_FRAME_BYTES(MAX_B), .MIN_FRAME_BYTES(MIN_B)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_bus (bus)
    );

`ifdef AXIS_MII_RX_LEN_CHECK_EN
    assign len_obs = bus.length_error;
`else
    assign len_obs = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.axis_valid)
                beats.push_back('{bus.axis_data, bus.axis_last, bus.axis_err, cyc});
            if (bus.frame_ok | bus.fcs_error | bus.align_error | bus.rx_error | len_obs)
                stats.push_back('{bus.frame_ok, bus.fcs_error, bus.align_error, bus.rx_error, len_obs, cyc});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ethernet CRC-32 computed bit-serially over the whole message, complemented at the end.
    function automatic logic [31:0] crc32(input bq_t b);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic bq_t with_fcs(input bq_t pay);
        bq_t         r;
        logic [31:0] f;
        r = pay;
        f = crc32(pay);
        for (int i = 0; i < 4; i++) r.push_back(f[8*i +: 8]);
        return r;
    endfunction

    task automatic nib(input logic dv, input logic er, input logic [3:0] d);
        @(negedge clk);
        bus.mii_rx_ce = 1'b1;
        bus.mii_rx_dv = dv;
        bus.mii_rx_er = er;
        bus.mii_rxd   = d;
        last_ce       = cyc;
        @(negedge clk);
        bus.mii_rx_ce = 1'b0;
    endtask

    task automatic preamble(input bit broken);
        for (int i = 0; i < 15; i++) nib(1'b1, 1'b0, (broken && i == 6) ? 4'h3 : 4'h5);
        nib(1'b1, 1'b0, 4'hD);
    endtask

    task automatic send_frame(input bq_t b, input bit broken, input int er_nib, input bit extra);
        preamble(broken);
        foreach (b[i]) begin
            nib(1'b1, (2*i == er_nib), b[i][3:0]);
            nib(1'b1, (2*i+1 == er_nib), b[i][7:4]);
        end
        if (extra) nib(1'b1, 1'b0, 4'($urandom_range(0, 15)));
        nib(1'b0, 1'b0, 4'h0);
        eof_ce = last_ce;
        repeat (3) nib(1'b0, 1'b0, 4'h0);
    endtask

    // Reference: everything but the trailing 4 octets is payload; judge FCS, alignment, er, length.
    task automatic check_frame(input string name, input bq_t b, input bit broken, input bit er, input bit extra);
        int   n, nb;
        bit   over, len_bad, fcs_ok, bad;
        bq_t  body;
        n       = b.size();
        over    = 0;
        len_bad = 0;
`ifdef AXIS_MII_RX_LEN_CHECK_EN
        len_bad = (n < MIN_B) || (n > MAX_B);
        over    = (n > MAX_B);
`endif
        if (broken) begin
            chk({name, " beats"}, beats.size(), 0);
            chk({name, " stats"}, stats.size(), 0);
        end else begin
            if (over) begin
                nb     = MAX_B - 4;
                fcs_ok = 1;
                bad    = 1;
            end else begin
                nb   = (n >= 5) ? n - 4 : 0;
                body = {};
                for (int i = 0; i < nb; i++) body.push_back(b[i]);
                fcs_ok = (n >= 5) && (crc32(body) == {b[n-1], b[n-2], b[n-3], b[n-4]});
                bad    = !fcs_ok || extra || er || len_bad;
            end
            chk({name, " beats"}, beats.size(), nb);
            for (int i = 0; i < nb && i < beats.size(); i++) begin
                chk({name, " data"}, beats[i].d, b[i]);
                chk({name, " last"}, beats[i].l, (i == nb - 1));
            end
            if (nb > 0 && beats.size() == nb) begin
                chk({name, " err"}, beats[nb-1].e, bad);
                if (!over) chk({name, " beat latency"}, beats[nb-1].cyc, eof_ce + 1);
            end
            chk({name, " stats"}, stats.size(), 1);
            if (stats.size() == 1) begin
                chk({name, " frame_ok"}, stats[0].ok, !bad);
                chk({name, " fcs_error"}, stats[0].fcs, over ? 1'b0 : !fcs_ok);
                chk({name, " align_error"}, stats[0].aln, over ? 1'b0 : extra);
                chk({name, " rx_error"}, stats[0].rxe, er);
                chk({name, " length_error"}, stats[0].len, len_bad);
                if (!over) chk({name, " stat latency"}, stats[0].cyc, eof_ce + 1);
            end
        end
        beats.delete();
        stats.delete();
    endtask

    initial begin
        bq_t pay, fr;
        int  plen, mode, er_nib, nlast;
        bit  extra;
        bus.mii_rx_ce = 1'b0;
        bus.mii_rx_dv = 1'b0;
        bus.mii_rx_er = 1'b0;
        bus.mii_rxd   = 4'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset valid", bus.axis_valid, 0);
        chk("reset last", bus.axis_last, 0);
        chk("reset err", bus.axis_err, 0);
        chk("reset data", bus.axis_data, 0);
        chk("reset status", {bus.frame_ok, bus.fcs_error, bus.align_error, bus.rx_error, len_obs}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pay = {};
        for (int i = 0; i < 60; i++) pay.push_back(8'(i));
        fr = with_fcs(pay);
        send_frame(fr, 0, -1, 0);
        check_frame("good", fr, 0, 0, 0);

        fr = with_fcs(pay);
        fr[10] ^= 8'h01;
        send_frame(fr, 0, -1, 0);
        check_frame("fcs_bad", fr, 0, 0, 0);

        fr = with_fcs(pay);
        send_frame(fr, 0, 40, 0);
        check_frame("rx_er", fr, 0, 1, 0);

        send_frame(fr, 0, -1, 1);
        check_frame("align", fr, 0, 0, 1);

        send_frame(fr, 1, -1, 0);
        check_frame("broken_pre", fr, 1, 0, 0);

        fr = {};
        fr.push_back(8'h11);
        fr.push_back(8'h22);
        fr.push_back(8'h33);
        send_frame(fr, 0, -1, 0);
        check_frame("short3", fr, 0, 0, 0);

        fr = with_fcs(pay);
        preamble(0);
        for (int i = 0; i < 30; i++) begin
            nib(1'b1, 1'b0, fr[i][3:0]);
            nib(1'b1, 1'b0, fr[i][7:4]);
        end
        repeat (2) @(negedge clk);
        chk("pre_rst beats", beats.size(), 25);
        nlast = 0;
        foreach (beats[i]) if (beats[i].l) nlast++;
        chk("pre_rst lasts", nlast, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst valid", bus.axis_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        beats.delete();
        stats.delete();
        repeat (3) nib(1'b0, 1'b0, 4'h0);
        chk("post_rst beats", beats.size(), 0);
        chk("post_rst stats", stats.size(), 0);
        send_frame(fr, 0, -1, 0);
        check_frame("after_rst", fr, 0, 0, 0);

        for (int t = 0; t < 10; t++) begin
            plen = $urandom_range(0, 70);
            pay  = {};
            for (int i = 0; i < plen; i++) pay.push_back(8'($urandom));
            fr     = with_fcs(pay);
            mode   = $urandom_range(0, 3);
            er_nib = -1;
            extra  = 0;
            case (mode)
                1:       fr[$urandom_range(0, fr.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
                2:       er_nib = $urandom_range(0, 2 * fr.size() - 1);
                3:       extra = 1;
                default: ;
            endcase
            send_frame(fr, 0, er_nib, extra);
            check_frame("random", fr, 0, (er_nib >= 0), extra);
        end

`ifdef AXIS_MII_RX_LEN_CHECK_EN
        pay = {};
        for (int i = 0; i < 59; i++) pay.push_back(8'($urandom));
        fr = with_fcs(pay);
        send_frame(fr, 0, -1, 0);
        check_frame("len63", fr, 0, 0, 0);

        pay = {};
        for (int i = 0; i < 1515; i++) pay.push_back(8'($urandom));
        fr = with_fcs(pay);
        send_frame(fr, 0, -1, 0);
        check_frame("len1519", fr, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
